// File: rtl/vram_access_arbiter.sv
// Arbitrates the video tile-fetch and CPU ports onto the two 8Kx8 tilemap SRAMs and
// generates registered CEn/OEn/WEn/DOE strobe timing for each access.
module vram_access_arbiter #(
  parameter int RD_CYC     = 3,
  parameter int WR_CYC     = 2,
  parameter int CPU_STARVE = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        VID_REQ,
  input  logic [13:0] VID_ADDR,
  output logic        VID_ACK,
  output logic [7:0]  VID_DATA,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [13:0] CPU_ADDR,
  input  logic [7:0]  CPU_DIN,
  output logic        CPU_ACK,
  output logic [7:0]  CPU_DOUT,
  output logic [12:0] RAM_ADDR,
  output logic        RAM_CE0n,
  output logic        RAM_CE1n,
  output logic        RAM_OEn,
  output logic        RAM_WEn,
  output logic [7:0]  RAM_DOUT,
  output logic        RAM_DOE,
  input  logic [7:0]  RAM_DIN,
  output logic        BUSY
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WSET = 3'd2;
  localparam logic [2:0] S_WPUL = 3'd3;
  localparam logic [2:0] S_WHLD = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int CYC_MAX = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CNT_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int STV_W   = $clog2(CPU_STARVE + 1);

  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_CYC - 1);
  localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(CPU_STARVE);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             owner_cpu_q, owner_cpu_d;
  logic [STV_W-1:0] starve_q, starve_d;
  logic [12:0]      addr_q, addr_d;
  logic             ce0n_q, ce0n_d;
  logic             ce1n_q, ce1n_d;
  logic             oen_q, oen_d;
  logic             wen_q, wen_d;
  logic             doe_q, doe_d;
  logic [7:0]       dout_q, dout_d;
  logic [7:0]       vid_data_q, vid_data_d;
  logic [7:0]       cpu_dout_q, cpu_dout_d;
  logic             vid_ack_q, vid_ack_d;
  logic             cpu_ack_q, cpu_ack_d;
  logic             busy_q, busy_d;

  logic cpu_grant;
  logic vid_grant;

  // CPU only beats a pending video request once video has used up its allowance.
  always_comb begin
    cpu_grant = 1'b0;
    vid_grant = 1'b0;
    if (state_q == S_IDLE) begin
      cpu_grant = CPU_REQ && (!VID_REQ || (starve_q == STARVE_MAX));
      vid_grant = VID_REQ && !cpu_grant;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!CPU_REQ || cpu_grant) begin
      starve_d = '0;
    end else if (vid_grant && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    owner_cpu_d = owner_cpu_q;
    addr_d      = addr_q;
    ce0n_d      = ce0n_q;
    ce1n_d      = ce1n_q;
    oen_d       = oen_q;
    wen_d       = wen_q;
    doe_d       = doe_q;
    dout_d      = dout_q;
    vid_data_d  = vid_data_q;
    cpu_dout_d  = cpu_dout_q;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_grant) begin
          owner_cpu_d = 1'b1;
          addr_d      = CPU_ADDR[12:0];
          ce0n_d      = CPU_ADDR[13];
          ce1n_d      = !CPU_ADDR[13];
          cyc_d       = '0;
          wen_d       = 1'b1;
          if (CPU_WE) begin
            state_d = S_WSET;
            oen_d   = 1'b1;
            doe_d   = 1'b1;
            dout_d  = CPU_DIN;
          end else begin
            state_d = S_RD;
            oen_d   = 1'b0;
            doe_d   = 1'b0;
          end
        end else if (vid_grant) begin
          owner_cpu_d = 1'b0;
          addr_d      = VID_ADDR[12:0];
          ce0n_d      = VID_ADDR[13];
          ce1n_d      = !VID_ADDR[13];
          cyc_d       = '0;
          state_d     = S_RD;
          oen_d       = 1'b0;
          wen_d       = 1'b1;
          doe_d       = 1'b0;
        end
      end

      // The capture happens on the edge that ends the last strobe cycle, so the data
      // register and the ACK pulse become visible together in DONE.
      S_RD: begin
        if (cyc_q == RD_LAST) begin
          state_d = S_DONE;
          ce0n_d  = 1'b1;
          ce1n_d  = 1'b1;
          oen_d   = 1'b1;
          if (owner_cpu_q) begin
            cpu_dout_d = RAM_DIN;
            cpu_ack_d  = 1'b1;
          end else begin
            vid_data_d = RAM_DIN;
            vid_ack_d  = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end

      S_WSET: begin
        state_d = S_WPUL;
        cyc_d   = '0;
        wen_d   = 1'b0;
      end

      S_WPUL: begin
        if (cyc_q == WR_LAST) begin
          state_d = S_WHLD;
          wen_d   = 1'b1;
        end else begin
          cyc_d = cyc_q + CNT_W'(1);
        end
      end

      S_WHLD: begin
        state_d   = S_DONE;
        ce0n_d    = 1'b1;
        ce1n_d    = 1'b1;
        doe_d     = 1'b0;
        cpu_ack_d = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        ce0n_d  = 1'b1;
        ce1n_d  = 1'b1;
        oen_d   = 1'b1;
        wen_d   = 1'b1;
        doe_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      owner_cpu_q <= 1'b0;
      starve_q    <= '0;
      addr_q      <= '0;
      ce0n_q      <= 1'b1;
      ce1n_q      <= 1'b1;
      oen_q       <= 1'b1;
      wen_q       <= 1'b1;
      doe_q       <= 1'b0;
      dout_q      <= '0;
      vid_data_q  <= '0;
      cpu_dout_q  <= '0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      owner_cpu_q <= owner_cpu_d;
      starve_q    <= starve_d;
      addr_q      <= addr_d;
      ce0n_q      <= ce0n_d;
      ce1n_q      <= ce1n_d;
      oen_q       <= oen_d;
      wen_q       <= wen_d;
      doe_q       <= doe_d;
      dout_q      <= dout_d;
      vid_data_q  <= vid_data_d;
      cpu_dout_q  <= cpu_dout_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign VID_ACK  = vid_ack_q;
  assign VID_DATA = vid_data_q;
  assign CPU_ACK  = cpu_ack_q;
  assign CPU_DOUT = cpu_dout_q;
  assign RAM_ADDR = addr_q;
  assign RAM_CE0n = ce0n_q;
  assign RAM_CE1n = ce1n_q;
  assign RAM_OEn  = oen_q;
  assign RAM_WEn  = wen_q;
  assign RAM_DOUT = dout_q;
  assign RAM_DOE  = doe_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Directed bench for vram_access_arbiter: SRAM model, per-transaction vector table and
// hand-written sequences for arbitration, starvation and mid-transaction reset.
module tb_vram_access_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        VID_REQ;
  logic [13:0] VID_ADDR;
  logic        VID_ACK;
  logic [7:0]  VID_DATA;
  logic        CPU_REQ;
  logic        CPU_WE;
  logic [13:0] CPU_ADDR;
  logic [7:0]  CPU_DIN;
  logic        CPU_ACK;
  logic [7:0]  CPU_DOUT;
  logic [12:0] RAM_ADDR;
  logic        RAM_CE0n;
  logic        RAM_CE1n;
  logic        RAM_OEn;
  logic        RAM_WEn;
  logic [7:0]  RAM_DOUT;
  logic        RAM_DOE;
  logic [7:0]  RAM_DIN;
  logic        BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  vram_access_arbiter dut (
    .CLK      (CLK),
    .RST      (RST),
    .VID_REQ  (VID_REQ),
    .VID_ADDR (VID_ADDR),
    .VID_ACK  (VID_ACK),
    .VID_DATA (VID_DATA),
    .CPU_REQ  (CPU_REQ),
    .CPU_WE   (CPU_WE),
    .CPU_ADDR (CPU_ADDR),
    .CPU_DIN  (CPU_DIN),
    .CPU_ACK  (CPU_ACK),
    .CPU_DOUT (CPU_DOUT),
    .RAM_ADDR (RAM_ADDR),
    .RAM_CE0n (RAM_CE0n),
    .RAM_CE1n (RAM_CE1n),
    .RAM_OEn  (RAM_OEn),
    .RAM_WEn  (RAM_WEn),
    .RAM_DOUT (RAM_DOUT),
    .RAM_DOE  (RAM_DOE),
    .RAM_DIN  (RAM_DIN),
    .BUSY     (BUSY)
  );

  // Two 8Kx8 SRAMs; contents preloaded while reset is held.
  logic [7:0] mem_lo [0:8191];
  logic [7:0] mem_hi [0:8191];

  always @(posedge CLK) begin
    if (RST) begin
      mem_lo[13'h0123] <= 8'h5A;
      mem_lo[13'h1FFF] <= 8'hC3;
      mem_lo[13'h0004] <= 8'h44;
      mem_lo[13'h0008] <= 8'h88;
      mem_hi[13'h1FFF] <= 8'h81;
    end else if (!RAM_WEn && RAM_DOE) begin
      if (!RAM_CE0n) mem_lo[RAM_ADDR] <= RAM_DOUT;
      if (!RAM_CE1n) mem_hi[RAM_ADDR] <= RAM_DOUT;
    end
  end

  assign RAM_DIN = (!RAM_OEn && !RAM_CE0n) ? mem_lo[RAM_ADDR] :
                   (!RAM_OEn && !RAM_CE1n) ? mem_hi[RAM_ADDR] : 8'hEE;

  typedef struct {
    bit          is_cpu;
    bit          we;
    logic [13:0] addr;
    logic [7:0]  din;
    logic [7:0]  exp_data;
    int          exp_lat;
    int          exp_ce0;
    int          exp_ce1;
    int          exp_oe;
    int          exp_we;
    int          exp_doe;
    logic [12:0] exp_raddr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe rules that must hold on every observed cycle.
  task automatic rules();
    n_checks++;
    if ((!RAM_OEn && !RAM_WEn) || (RAM_DOE && !RAM_OEn) || (!RAM_CE0n && !RAM_CE1n)) begin
      n_fail++;
      $display("FAIL strobe_rules: OEn=%b WEn=%b DOE=%b CE0n=%b CE1n=%b, expected no OE/WE, DOE/OE or CE0/CE1 overlap",
               RAM_OEn, RAM_WEn, RAM_DOE, RAM_CE0n, RAM_CE1n);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, ce0, ce1, oe, wec, doe, webad, wrong;
    bit got;
    logic [7:0]  data;
    logic [12:0] raddr;
    lat = 0; ce0 = 0; ce1 = 0; oe = 0; wec = 0; doe = 0; webad = 0; wrong = 0;
    got = 1'b0; data = 8'h00; raddr = '0;
    @(negedge CLK);
    if (v.is_cpu) begin
      CPU_REQ = 1'b1; CPU_WE = v.we; CPU_ADDR = v.addr; CPU_DIN = v.din;
    end else begin
      VID_REQ = 1'b1; VID_ADDR = v.addr;
    end
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge CLK);
      rules();
      if (c == 1) raddr = RAM_ADDR;
      if (!RAM_CE0n) ce0++;
      if (!RAM_CE1n) ce1++;
      if (!RAM_OEn)  oe++;
      if (!RAM_WEn)  wec++;
      if (RAM_DOE)   doe++;
      if (!RAM_WEn && !RAM_DOE) webad++;
      if (v.is_cpu ? VID_ACK : CPU_ACK) wrong++;
      if (v.is_cpu ? CPU_ACK : VID_ACK) begin
        got  = 1'b1;
        lat  = c;
        data = v.is_cpu ? CPU_DOUT : VID_DATA;
      end
    end
    CPU_REQ = 1'b0;
    VID_REQ = 1'b0;
    chk($sformatf("v%0d_ack_seen", idx), int'(got), 1);
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    if (!v.we) chk($sformatf("v%0d_data", idx), int'(data), int'(v.exp_data));
    chk($sformatf("v%0d_ce0_cycles", idx), ce0, v.exp_ce0);
    chk($sformatf("v%0d_ce1_cycles", idx), ce1, v.exp_ce1);
    chk($sformatf("v%0d_oe_cycles", idx), oe, v.exp_oe);
    chk($sformatf("v%0d_we_cycles", idx), wec, v.exp_we);
    chk($sformatf("v%0d_doe_cycles", idx), doe, v.exp_doe);
    chk($sformatf("v%0d_ram_addr", idx), int'(raddr), int'(v.exp_raddr));
    chk($sformatf("v%0d_we_outside_doe", idx), webad, 0);
    chk($sformatf("v%0d_wrong_ack", idx), wrong, 0);
    $display("vec %0d: %s %s addr=%h lat=%0d data=%h", idx, v.is_cpu ? "cpu" : "vid",
             v.we ? "wr" : "rd", v.addr, lat, data);
  endtask

  initial begin
    int vid_at, cpu_at, k, acks;

    //            cpu  we   addr      din    data   lat ce0 ce1 oe we doe raddr
    vecs[0] = '{1'b1, 1'b0, 14'h0123, 8'h00, 8'h5A, 4, 3, 0, 3, 0, 0, 13'h0123};
    vecs[1] = '{1'b1, 1'b1, 14'h2010, 8'hA5, 8'h00, 5, 0, 4, 0, 2, 4, 13'h0010};
    vecs[2] = '{1'b0, 1'b0, 14'h2010, 8'h00, 8'hA5, 4, 0, 3, 3, 0, 0, 13'h0010};
    vecs[3] = '{1'b0, 1'b0, 14'h1FFF, 8'h00, 8'hC3, 4, 3, 0, 3, 0, 0, 13'h1FFF};
    vecs[4] = '{1'b1, 1'b1, 14'h0000, 8'h3C, 8'h00, 5, 4, 0, 0, 2, 4, 13'h0000};
    vecs[5] = '{1'b1, 1'b0, 14'h0000, 8'h00, 8'h3C, 4, 3, 0, 3, 0, 0, 13'h0000};
    vecs[6] = '{1'b0, 1'b0, 14'h3FFF, 8'h00, 8'h81, 4, 0, 3, 3, 0, 0, 13'h1FFF};
    vecs[7] = '{1'b1, 1'b0, 14'h2010, 8'h00, 8'hA5, 4, 0, 3, 3, 0, 0, 13'h0010};

    RST = 1'b1; VID_REQ = 1'b0; VID_ADDR = '0;
    CPU_REQ = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_DIN = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset held two cycles while idle.
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    rules();
    chk("rst_ce0n", int'(RAM_CE0n), 1);
    chk("rst_ce1n", int'(RAM_CE1n), 1);
    chk("rst_oen", int'(RAM_OEn), 1);
    chk("rst_wen", int'(RAM_WEn), 1);
    chk("rst_doe", int'(RAM_DOE), 0);
    chk("rst_acks", int'({VID_ACK, CPU_ACK}), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_ram_addr", int'(RAM_ADDR), 0);
    $display("reset idle: CE0n=%b CE1n=%b OEn=%b WEn=%b DOE=%b BUSY=%b", RAM_CE0n, RAM_CE1n,
             RAM_OEn, RAM_WEn, RAM_DOE, BUSY);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    chk("vid_data_held", int'(VID_DATA), 8'h81);

    // Simultaneous requests: video first, CPU immediately after.
    @(negedge CLK);
    VID_REQ = 1'b1; VID_ADDR = 14'h0004;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 14'h0008;
    vid_at = 0; cpu_at = 0;
    for (int c = 1; c <= 30 && !(vid_at != 0 && cpu_at != 0); c++) begin
      @(negedge CLK);
      rules();
      if (VID_ACK && vid_at == 0) begin
        vid_at = c; VID_REQ = 1'b0;
        chk("both_vid_data", int'(VID_DATA), 8'h44);
      end
      if (CPU_ACK && cpu_at == 0) begin
        cpu_at = c; CPU_REQ = 1'b0;
        chk("both_cpu_data", int'(CPU_DOUT), 8'h88);
      end
    end
    VID_REQ = 1'b0; CPU_REQ = 1'b0;
    chk("both_vid_ack_cycle", vid_at, 4);
    chk("both_cpu_ack_cycle", cpu_at, 9);
    $display("simultaneous: vid ack cycle %0d, cpu ack cycle %0d", vid_at, cpu_at);

    // Both held continuously: four video grants, then the CPU, repeating.
    @(negedge CLK);
    VID_REQ = 1'b1; VID_ADDR = 14'h0004;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 14'h0008;
    k = 0;
    for (int c = 1; c <= 200 && k < 10; c++) begin
      @(negedge CLK);
      rules();
      if (VID_ACK || CPU_ACK) begin
        chk($sformatf("starve_ack%0d_is_cpu", k), int'(CPU_ACK), (k % 5 == 4) ? 1 : 0);
        chk($sformatf("starve_ack%0d_data", k), int'(CPU_ACK ? CPU_DOUT : VID_DATA),
            (k % 5 == 4) ? 8'h88 : 8'h44);
        $display("starve ack %0d: %s", k, CPU_ACK ? "cpu" : "vid");
        k++;
      end
    end
    VID_REQ = 1'b0; CPU_REQ = 1'b0;
    chk("starve_ack_count", k, 10);

    // Reset during the write pulse drops the transaction.
    @(negedge CLK);
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 14'h0100; CPU_DIN = 8'h77;
    @(negedge CLK);
    rules();
    chk("wr_wset_doe", int'(RAM_DOE), 1);
    chk("wr_wset_wen", int'(RAM_WEn), 1);
    @(negedge CLK);
    rules();
    chk("wr_wpul_wen", int'(RAM_WEn), 0);
    RST = 1'b1; CPU_REQ = 1'b0;
    @(negedge CLK);
    rules();
    chk("rst_wpul_wen", int'(RAM_WEn), 1);
    chk("rst_wpul_doe", int'(RAM_DOE), 0);
    chk("rst_wpul_ce0n", int'(RAM_CE0n), 1);
    chk("rst_wpul_busy", int'(BUSY), 0);
    chk("rst_wpul_cpu_ack", int'(CPU_ACK), 0);
    chk("rst_wpul_cpu_dout", int'(CPU_DOUT), 0);
    chk("rst_wpul_vid_data", int'(VID_DATA), 0);
    $display("reset in WPUL: WEn=%b DOE=%b BUSY=%b", RAM_WEn, RAM_DOE, BUSY);
    @(negedge CLK);
    RST = 1'b0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      rules();
      if (CPU_ACK || VID_ACK) acks++;
    end
    chk("rst_no_late_ack", acks, 0);
    run_vec(vecs[0], 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
